// File: rtl/rr_arb_mux_pkg.sv
// Shared constants and types for the round-robin arbitrated 4:1 payload mux.
// Also holds the helper that finds the first set bit of a pointer-rotated request vector.
package rr_arb_mux_pkg;

  localparam int N_REQ  = 4;
  localparam int DATA_W = 4;

  typedef logic [1:0] src_t;

  // Offset of the first set bit in a request vector already rotated so bit 0 is at ptr.
  function automatic src_t rr_offset(input logic [N_REQ-1:0] rot);
    src_t off;
    if (rot[0]) begin
      off = 2'd0;
    end else if (rot[1]) begin
      off = 2'd1;
    end else if (rot[2]) begin
      off = 2'd2;
    end else begin
      off = 2'd3;
    end
    return off;
  endfunction

endpackage

// File: rtl/mux_4_1.sv
// Plain 4-bit 4:1 multiplexer.
// Only the selected input can reach y, so unknowns on the other inputs never propagate.
module mux_4_1
  import rr_arb_mux_pkg::*;
(
  input  logic [DATA_W-1:0] d0,
  input  logic [DATA_W-1:0] d1,
  input  logic [DATA_W-1:0] d2,
  input  logic [DATA_W-1:0] d3,
  input  src_t              sel,
  output logic [DATA_W-1:0] y
);

  // Select exactly one payload.
  always_comb begin
    y = 4'd0;
    case (sel)
      2'd0:    y = d0;
      2'd1:    y = d1;
      2'd2:    y = d2;
      2'd3:    y = d3;
      default: y = 4'd0;
    endcase
  end

endmodule

// File: rtl/rr_arb_mux_4_1.sv
// Round-robin arbiter over four valid/ready requesters.
// Feeds a one-entry registered output stage that can drain and refill in the same cycle.
module rr_arb_mux_4_1
  import rr_arb_mux_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [N_REQ-1:0]  in_valid,
  input  logic [DATA_W-1:0] d0,
  input  logic [DATA_W-1:0] d1,
  input  logic [DATA_W-1:0] d2,
  input  logic [DATA_W-1:0] d3,
  output logic [N_REQ-1:0]  in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output src_t              out_src
);

  src_t              ptr;
  src_t              win;
  logic              free;
  logic              grant;
  logic [2*N_REQ-1:0] rot_wide;
  logic [DATA_W-1:0] win_data;

  // Winner search: rotate requests so ptr lands on bit 0, then take the first set bit.
  always_comb begin
    rot_wide = {in_valid, in_valid} >> ptr;
    win      = ptr + rr_offset(rot_wide[N_REQ-1:0]);
    free     = ~out_valid | out_ready;
    grant    = free & (|in_valid) & ~rst;
    if (grant) begin
      in_ready = 4'b0001 << win;
    end else begin
      in_ready = 4'b0000;
    end
  end

  mux_4_1 u_mux (
    .d0  (d0),
    .d1  (d1),
    .d2  (d2),
    .d3  (d3),
    .sel (win),
    .y   (win_data)
  );

  // Output register and pointer; ptr only advances on an accepted grant and wraps naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= 4'd0;
      out_src   <= 2'd0;
      ptr       <= 2'd0;
    end else if (grant) begin
      out_valid <= 1'b1;
      out_data  <= win_data;
      out_src   <= win;
      ptr       <= win + 2'd1;
    end else if (free) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= out_valid;
    end
  end

endmodule
